muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Sequencer for the iterative multiply/divide unit and owner of the HI/LO register pair.
//  Accepts MULT/MULTU/DIV/DIVU from EX and runs a shift-add multiply or restoring divide.
//  Writes the result to HI/LO and raises a stall to ID while a HI/LO consumer must wait.
//  Also applies MTHI/MTLO writes from WB. Sits beside the EX stage; feeds the HI/LO forwarding path.
// PARAMETERS
//  WIDTH    32   operand width; HI and LO are each WIDTH bits
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start_i    in   1      EX issues a mult/div this cycle
//  op_i       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a_i        in   WIDTH  rs operand (multiplicand / dividend)
//  b_i        in   WIDTH  rt operand (multiplier / divisor)
//  flush_i    in   1      pipeline flush; aborts any in-flight op
//  mthi_i     in   1      WB writes HI
//  mtlo_i     in   1      WB writes LO
//  wdata_i    in   WIDTH  MTHI/MTLO data
//  hilo_use_i in   1      ID holds an instruction that reads or writes HI/LO, or starts mult/div
//  busy_o     out  1      operation in flight (state != IDLE)
//  stall_o    out  1      combinational: busy_o & hilo_use_i
//  done_o     out  1      one-cycle pulse: new HI/LO visible this cycle
//  div0_o     out  1      one-cycle pulse with done_o when the divisor was zero
//  hi_o       out  WIDTH  HI register
//  lo_o       out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, cnt=0, hi_o=lo_o=0, busy_o=done_o=div0_o=0.
//  States: IDLE -> MUL | DIV -> FIX -> IDLE.
//  IDLE + start_i (flush_i=0):
//   - Latch operands as magnitudes: abs() for MULT/DIV, raw for MULTU/DIVU.
//   - Record sign_a and sign_b; set cnt=WIDTH.
//   - Go to MUL or DIV. DIV/DIVU with b_i==0 goes straight to FIX with the div0 flag set.
//  start_i while busy_o=1: ignored. ID stall makes this illegal; the bench asserts it never occurs.
//  MUL: 2*WIDTH accumulator; each cycle add the multiplicand to the upper half if the multiplier LSB is 1.
//   Then shift the {acc, multiplier} pair right 1. cnt-- each cycle; at cnt==1 go to FIX.
//  DIV: restoring; each cycle shift {rem,quot} left 1; if rem>=divisor, subtract and set quot LSB.
//   cnt-- each cycle; at cnt==1 go to FIX.
//  FIX (1 cycle), at its closing edge:
//   - MULT: product negated if sign_a^sign_b; {hi,lo} <= product.
//   - DIV: LO=quot, negated if sign_a^sign_b. HI=rem, negated if sign_a.
//   - Divide by zero: HI=a_i as latched (raw), LO=all ones; div0_o pulses.
//   - Unsigned variants: no negation.
//   - Set done_o=1 for exactly the next cycle; state IDLE.
//  Latency (start sampled at edge E0):
//   - busy_o=1 from E0 to E0+WIDTH+1 (WIDTH+1 cycles).
//   - HI/LO updated and done_o=1 at E0+WIDTH+2.
//   - Divide by zero: busy_o 1 cycle; result at E0+2.
//  flush_i in MUL/DIV/FIX: next edge -> IDLE, HI/LO untouched, no done_o.
//  flush_i with start_i in IDLE: no op starts.
//  MTHI/MTLO: applied at any edge, including while busy (older instruction draining WB).
//   The result write on the same edge as the FIX write wins for that register.
//  Arithmetic: abs(-2^(WIDTH-1)) = 2^(WIDTH-1), held unsigned in WIDTH bits. All sums are WIDTH+1 bits, no overflow.
// TESTING
//  MULTU FFFFFFFF*FFFFFFFF -> busy 33 cycles; at E0+34 HI=FFFFFFFE, LO=00000001, done_o 1 cycle.
//  MULT -3*7 -> HI=FFFFFFFF, LO=FFFFFFEB; MULT 80000000*80000000 -> HI=40000000, LO=0.
//  DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 100/7 -> LO=0000000E, HI=00000002.
//  DIV 5/0 -> done_o and div0_o at E0+2, HI=00000005, LO=FFFFFFFF.
//  hilo_use_i=1 during MUL -> stall_o=1 until the done_o cycle; flush_i at cycle 10 -> busy_o=0 next cycle, HI/LO unchanged.
//  mtlo_i (wdata 1234) on the FIX edge -> LO takes the product. rst_n low mid-DIV -> all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer that owns the HI/LO register pair.
// Shift-add multiply and restoring divide run on operand magnitudes; the signs are applied in FIX.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             hilo_use_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic             div0_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start_i is a single-cycle request that is accepted only in IDLE with
  // flush_i low; the unit answers with exactly one done_o pulse, or nothing if flushed.
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, mq_q, opd_q, hi_q, lo_q;
  logic             sign_a_q, sign_b_q, is_div_q, div0_flag_q, done_q, div0_q;

  logic             signed_op, start_ok, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign signed_op = ~op_i[0];
  assign a_mag     = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag     = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;
  assign start_ok  = start_i & ~flush_i & (state_q == IDLE);
  assign b_zero    = (b_i == '0);

  assign mul_sum  = {1'b0, acc_q} + {1'b0, (mq_q[0] ? opd_q : '0)};
  assign div_sh   = {acc_q, mq_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opd_q};
  // The remainder always stays below the divisor, so a borrow out of bit WIDTH means rem < divisor.
  assign div_ge   = ~div_diff[WIDTH];

  assign prod     = {acc_q, mq_q};
  assign prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
  assign quot_fix = (sign_a_q ^ sign_b_q) ? -mq_q : mq_q;
  assign rem_fix  = sign_a_q ? -acc_q : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = op_i[1] ? (b_zero ? FIX : DIV) : MUL;
      MUL, DIV: begin
        if (flush_i)                 state_d = IDLE;
        else if (cnt_q == CW'(1))    state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      opd_q       <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      is_div_q    <= 1'b0;
      div0_flag_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      if (mthi_i) hi_q <= wdata_i;
      if (mtlo_i) lo_q <= wdata_i;
      case (state_q)
        IDLE: if (start_ok) begin
          cnt_q       <= CW'(WIDTH);
          sign_a_q    <= signed_op & a_i[WIDTH-1];
          sign_b_q    <= signed_op & b_i[WIDTH-1];
          is_div_q    <= op_i[1];
          div0_flag_q <= op_i[1] & b_zero;
          if (op_i[1]) begin
            // A zero divisor skips iteration; acc holds the raw dividend for HI.
            acc_q <= b_zero ? a_i : '0;
            mq_q  <= a_mag;
            opd_q <= b_mag;
          end else begin
            acc_q <= '0;
            mq_q  <= b_mag;
            opd_q <= a_mag;
          end
        end
        MUL: begin
          acc_q <= mul_sum[WIDTH:1];
          mq_q  <= {mul_sum[0], mq_q[WIDTH-1:1]};
          cnt_q <= cnt_q - CW'(1);
        end
        DIV: begin
          acc_q <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
          mq_q  <= {mq_q[WIDTH-2:0], div_ge};
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: if (!flush_i) begin
          done_q <= 1'b1;
          div0_q <= div0_flag_q;
          if (div0_flag_q) begin
            hi_q <= acc_q;
            lo_q <= '1;
          end else if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign stall_o     = busy_o & hilo_use_i;
  assign done_o      = done_q;
  assign div0_o      = div0_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed and random ops against an arithmetic reference model,
// with a scoreboard monitor checking result, latency and busy length on every done pulse.
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk, rst_n;
  logic         start_i, flush_i, mthi_i, mtlo_i, hilo_use_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i, b_i, wdata_i;
  logic         busy_o, stall_o, done_o, div0_o;
  logic [W-1:0] hi_o, lo_o;
  logic [1:0]   dbg_state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_run = 0;
  logic [W-1:0] model_hi = '0, model_lo = '0;

  logic [2*W:0] exp_q[$];
  int           due_q[$];
  int           blen_q[$];

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i), .wdata_i(wdata_i),
    .hilo_use_i(hilo_use_i), .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
    .div0_o(div0_o), .hi_o(hi_o), .lo_o(lo_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: {div0, hi, lo}
  function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [2*W-1:0] p;
    logic [W-1:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op[1] && b == '0) return {1'b1, a, {W{1'b1}}};
    case (op)
      2'b00: begin p = sa * sb; return {1'b0, p}; end
      2'b01: begin p = ua * ub; return {1'b0, p}; end
      2'b10: begin q = W'(sa / sb); r = W'(sa % sb); return {1'b0, r, q}; end
      default: begin q = a / b; r = a % b; return {1'b0, r, q}; end
    endcase
  endfunction

  // driver: call at a negedge with the unit idle; returns at the following negedge
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W:0] exp, input bit track);
    int lat;
    lat = (op[1] && b == '0) ? 2 : W + 2;
    if (track) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + lat);
      blen_q.push_back(lat - 1);
      model_hi = exp[2*W-1:W];
      model_lo = exp[W-1:0];
    end
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout act=pending%0d exp=pending0", exp_q.size());
      exp_q.delete(); due_q.delete(); blen_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b, model(op, a, b), 1'b1);
    wait_done();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd1;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_o) busy_run++;
      if (done_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done act=%h exp=none", {div0_o, hi_o, lo_o});
        end else begin
          check("result", {div0_o, hi_o, lo_o}, exp_q.pop_front());
          check("latency", (2*W+1)'(cyc), (2*W+1)'(due_q.pop_front()));
          check("busy_len", (2*W+1)'(busy_run), (2*W+1)'(blen_q.pop_front()));
        end
        busy_run = 0;
      end else begin
        if (div0_o) begin
          errors++;
          $display("FAIL div0_without_done act=1 exp=0");
        end
        if (!busy_o) busy_run = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && start_i && busy_o) begin
      errors++;
      $display("FAIL start_while_busy act=1 exp=0");
    end
  end

  initial begin
    logic [1:0] op;
    logic [W-1:0] a, b;
    int st;
    rst_n = 1'b0; start_i = 0; flush_i = 0; mthi_i = 0; mtlo_i = 0; hilo_use_i = 0;
    op_i = '0; a_i = '0; b_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {busy_o, done_o, div0_o, hi_o, lo_o}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed vectors from the arithmetic corner cases
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}, 1'b1); wait_done();
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b1); wait_done();
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, {1'b0, 32'h4000_0000, 32'h0}, 1'b1); wait_done();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1); wait_done();
    issue(2'b11, 32'd100, 32'd7, {1'b0, 32'h0000_0002, 32'h0000_000E}, 1'b1); wait_done();
    issue(2'b10, 32'd5, 32'd0, {1'b1, 32'h0000_0005, 32'hFFFF_FFFF}, 1'b1); wait_done();
    do_op(2'b10, 32'hFFFF_FFFB, 32'd0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(2'b10, 32'h8000_0000, 32'h8000_0000);

    // stall held for the whole busy window, released on the done cycle
    hilo_use_i = 1'b1;
    issue(2'b00, 32'd1234, 32'hFFFF_0000, model(2'b00, 32'd1234, 32'hFFFF_0000), 1'b1);
    st = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_o) break;
      if (stall_o) st++;
      @(negedge clk);
    end
    check("stall_len", (2*W+1)'(st), (2*W+1)'(W + 1));
    check("stall_at_done", {64'd0, stall_o}, '0);
    hilo_use_i = 1'b0;
    wait_done();

    // flush mid-multiply: no result, HI/LO untouched
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, '0, 1'b0);
    repeat (8) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy", {64'd0, busy_o}, '0);
    check("flush_hilo", {1'b0, hi_o, lo_o}, {1'b0, model_hi, model_lo});
    repeat (40) @(negedge clk);

    // flush together with start: nothing starts
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b11; a_i = 32'd9; b_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_start_busy", {64'd0, busy_o}, '0);

    // MTHI/MTLO while idle
    mthi_i = 1'b1; wdata_i = 32'hCAFE_0001;
    @(negedge clk);
    mthi_i = 1'b0; model_hi = 32'hCAFE_0001;
    mtlo_i = 1'b1; wdata_i = 32'hBEEF_0002;
    @(negedge clk);
    mtlo_i = 1'b0; model_lo = 32'hBEEF_0002;
    check("mt_idle", {1'b0, hi_o, lo_o}, {1'b0, model_hi, model_lo});

    // MTHI mid-multiply lands at once, then the result overwrites it
    issue(2'b00, 32'd11, 32'd13, model(2'b00, 32'd11, 32'd13), 1'b1);
    repeat (4) @(negedge clk);
    mthi_i = 1'b1; wdata_i = 32'h0BAD_F00D;
    @(negedge clk);
    mthi_i = 1'b0;
    check("mthi_busy", {33'd0, hi_o}, {33'd0, 32'h0BAD_F00D});
    wait_done();

    // MTLO on the same edge as the FIX write: the product wins
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b1);
    repeat (W) @(negedge clk);
    mtlo_i = 1'b1; wdata_i = 32'h0000_1234;
    @(negedge clk);
    mtlo_i = 1'b0;
    wait_done();

    // random operations
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = ($urandom_range(0, 7) == 0) ? '0 : pick();
      do_op(op, a, b);
    end

    // asynchronous reset in the middle of a divide
    issue(2'b10, 32'h7654_3210, 32'd37, model(2'b10, 32'h7654_3210, 32'd37), 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_div", {busy_o, done_o, div0_o, hi_o, lo_o}, '0);
    exp_q.delete(); due_q.delete(); blen_q.delete();
    busy_run = 0; model_hi = '0; model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b11, 32'hFFFF_FFFF, 32'd16);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
